instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the processor's 16-bit instruction register.
- On request from the control unit, it reads the word at the program counter from instruction memory, which has a fixed read latency.
- It then presents the word to the instruction register with a one-cycle write-enable pulse and advances the PC.
- It supports jumps and reports completion back to the control unit.

Parameters:
- data_width, 16, instruction word width; matches the instruction register width.
- addr_width, 16, PC and instruction-memory address width.
- mem_latency, 2, cycles from the mem_rd_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  control unit requests one instruction fetch; sampled only in IDLE.
- jump_en  in  1  load the PC from jump_addr; sampled only in IDLE.
- jump_addr  in  addr_width  jump target.
- mem_addr  out  addr_width  instruction memory address, registered.
- mem_rd_en  out  1  instruction memory read strobe, one cycle per fetch.
- mem_rdata  in  data_width  instruction memory read data.
- ir_data  out  data_width  registered fetched word; connects to the instruction register data input.
- ir_we  out  1  one-cycle pulse; connects to the instruction register write enable.
- pc  out  addr_width  current program counter.
- busy  out  1  high in every state except IDLE.
- fetch_done  out  1  one-cycle pulse, coincident with ir_we.

Behaviour:
- Reset values: state=IDLE, pc=0, mem_addr=0, ir_data=0, and mem_rd_en, ir_we, fetch_done, busy all 0.
- A reset mid-fetch aborts the fetch: no ir_we pulse is produced and the PC is not incremented.
- FSM states are IDLE, ISSUE, WAIT, LOAD.
- IDLE:
  - If jump_en=1, pc<=jump_addr.
  - If fetch_req=1, go to ISSUE with mem_addr<=(jump_en ? jump_addr : pc). A jump takes priority and is fetched in the same request.
  - If jump_en=1 and fetch_req=0, only the PC is updated.
- ISSUE: lasts exactly 1 cycle, with mem_rd_en=1 and mem_addr stable. Next state is WAIT and the wait counter is loaded with mem_latency.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1 (mem_latency cycles after the ISSUE cycle), mem_rdata is valid and is registered into ir_data.
  - Next state is LOAD.
- LOAD: lasts 1 cycle, with ir_we=1 and fetch_done=1. pc<=pc+1, modulo 2^addr_width (0xFFFF wraps to 0x0000). Next state is IDLE.
- Latency: with fetch_req sampled at edge 0, ISSUE is cycle 1 and LOAD is cycle 2+mem_latency. The instruction register holds the new word after the edge ending LOAD. With the default latency, a fetch takes 4 cycles and the next fetch can be accepted on the edge ending LOAD+1.
- fetch_req and jump_en are ignored while busy=1. Neither is queued.
- ir_data holds its value between fetches. The instruction register never sees a spurious ir_we.
- mem_addr holds its last value outside ISSUE.
- mem_rdata is ignored outside its valid cycle.

Optional Feature:
- Macro name: INSTR_FETCH_HALT_EN.
- With the macro defined:
  - Adds parameter halt_opcode (4 bits, default 4'hF) and an output halted (1 bit, reset value 0).
  - In LOAD, if ir_data[data_width-1:data_width-4]==halt_opcode, then halted<=1, the PC is not incremented, and later fetch_req and jump_en are ignored until rst.
  - ir_we still pulses for the halt word.
- Without the macro: no halted port, and every fetch behaves as above.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, LOAD=2'd3), the default data and address widths, and the default halt opcode.
- Sub-module pc_counter:
  - Register with synchronous reset, load (jump) and increment enables.
  - Increment wraps at addr_width.
  - Reusable by the branch unit.

Test Plan:
- Reset, then fetch_req at PC=0 with memory[0]=16'h1234 and mem_latency=2: mem_rd_en in cycle 1, mem_addr=0; ir_we and fetch_done in cycle 4 with ir_data=16'h1234; pc=1 afterwards.
- Three back-to-back fetches with memory[0..2]=16'hA001, A002, A003: the three ir_we pulses carry those values in order, and the final pc=3.
- jump_en and fetch_req together in IDLE with jump_addr=16'h00F0 and memory[F0]=16'hBEEF: mem_addr=16'h00F0, ir_data=16'hBEEF, pc ends at 16'h00F1.
- Jump to 16'hFFFF, then fetch: word is read from 16'hFFFF and pc wraps to 16'h0000.
- fetch_req pulsed during WAIT: ignored, with only one ir_we pulse.
- rst asserted during WAIT: outputs return to reset values next cycle, there is no ir_we, and pc=0.
- With INSTR_FETCH_HALT_EN defined and memory[0]=16'hF000: ir_we pulses, halted=1, pc stays 0, and a subsequent fetch_req produces no mem_rd_en.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the FSM state encoding,
// the default data and address widths, and the default halt opcode.
// The optional halt feature is enabled by the INSTR_FETCH_HALT_EN macro
// in the top level.
package instr_fetch_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;

  // Opcode (top nibble of the instruction word) that stops fetching.
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  // Width of the memory-latency wait counter; covers latencies 1..15.
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register. It has a synchronous reset and a load port for
// jumps, and it increments with wraparound at addr_width bits. It has no
// dependency on the fetch FSM, so the branch unit can reuse it.
module pc_counter
  import instr_fetch_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [addr_width-1:0] load_value,
  input  logic                  inc,
  output logic [addr_width-1:0] count
);

  // Load has priority over increment; the increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. It reads the word at the PC from a fixed-latency
// instruction memory, then hands the word to the instruction register with a
// one-cycle write-enable pulse, and then advances the PC.
// Optional feature: define INSTR_FETCH_HALT_EN. This adds a halt opcode
// that freezes the PC and blocks further requests until reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int addr_width  = ADDR_WIDTH,
  parameter int mem_latency = 2
`ifdef INSTR_FETCH_HALT_EN
  ,
  parameter logic [3:0] halt_opcode = HALT_OPCODE
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  jump_en,
  input  logic [addr_width-1:0] jump_addr,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [data_width-1:0] mem_rdata,
  output logic [data_width-1:0] ir_data,
  output logic                  ir_we,
  output logic [addr_width-1:0] pc,
  output logic                  busy,
  output logic                  fetch_done
`ifdef INSTR_FETCH_HALT_EN
  ,
  output logic                  halted
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAT_INIT = CNT_WIDTH'(mem_latency);

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 pc_load;
  logic                 pc_inc;
  logic                 addr_load;
  logic                 capture;
  logic                 halt_hit;
  logic                 halt_block;

`ifdef INSTR_FETCH_HALT_EN
  assign halt_hit   = (ir_data[data_width-1 -: 4] == halt_opcode);
  assign halt_block = halted;

  // Once a halt word has been loaded, stay halted until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (state == LOAD && halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_hit   = 1'b0;
  assign halt_block = 1'b0;
`endif

  pc_counter #(
    .addr_width(addr_width)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_value(jump_addr),
    .inc       (pc_inc),
    .count     (pc)
  );

  // State, the latency counter, the registered memory address and the
  // captured instruction word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_addr <= '0;
      ir_data  <= '0;
    end else begin
      state <= state_next;
      if (state == ISSUE) begin
        wait_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      // A jump issued together with a request is fetched immediately.
      if (addr_load) begin
        mem_addr <= jump_en ? jump_addr : pc;
      end
      if (capture) begin
        ir_data <= mem_rdata;
      end
    end
  end

  // Next-state logic and the per-state strobes. Requests reach the FSM only
  // in IDLE, so anything that arrives while busy is dropped.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    addr_load  = 1'b0;
    capture    = 1'b0;
    mem_rd_en  = 1'b0;
    ir_we      = 1'b0;
    fetch_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!halt_block) begin
          pc_load = jump_en;
          if (fetch_req) begin
            addr_load  = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_rd_en  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // The read data is valid mem_latency cycles after the ISSUE cycle.
        if (wait_cnt == CNT_WIDTH'(1)) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        ir_we      = 1'b1;
        fetch_done = 1'b1;
        pc_inc     = !halt_hit;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. The instruction memory model has a
// mem_latency-stage read pipeline. Outside the valid read cycle it drives
// 16'hDEAD, so the DUT must sample the read data in the correct cycle.
module tb_instr_fetch;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] ir_data;
  logic        ir_we;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_done;
`ifdef INSTR_FETCH_HALT_EN
  logic        halted;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] pipe_data [LAT];
  logic        pipe_vld  [LAT];

  instr_fetch #(
    .data_width (16),
    .addr_width (16),
    .mem_latency(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .ir_data   (ir_data),
    .ir_we     (ir_we),
    .pc        (pc),
    .busy      (busy),
    .fetch_done(fetch_done)
`ifdef INSTR_FETCH_HALT_EN
    ,
    .halted    (halted)
`endif
  );

  always #5 clk = ~clk;

  // Memory read pipeline: data requested in the mem_rd_en cycle becomes
  // visible LAT cycles later.
  always @(posedge clk) begin
    pipe_vld[0]  <= mem_rd_en;
    pipe_data[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) begin
      pipe_vld[i]  <= pipe_vld[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  assign mem_rdata = pipe_vld[LAT-1] ? pipe_data[LAT-1] : 16'hDEAD;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until ir_we is seen, bounded; n returns the number of steps taken.
  task automatic wait_we(input string tag, output int n);
    n = 0;
    while (!ir_we && n < 20) begin
      step();
      n++;
    end
    check({tag, "_we_seen"}, 32'(ir_we), 32'd1);
  endtask

  // One complete fetch. Any jump_en/jump_addr set by the caller is sampled
  // on the same edge as fetch_req.
  task automatic do_fetch(input string tag, input logic [15:0] exp_addr,
                          input logic [15:0] exp_data, input logic [15:0] exp_pc);
    int n;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    wait_we(tag, n);
    check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
    check({tag, "_done"}, 32'(fetch_done), 32'd1);
    check({tag, "_data"}, 32'(ir_data), 32'(exp_data));
    step();
    check({tag, "_we_off"}, 32'(ir_we), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(ir_data), 32'(exp_data));
  endtask

  initial begin
    int n;
    int we_cnt;
    int rd_cnt;
    logic [15:0] exp_seq [3];

    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
    for (int i = 0; i < LAT; i++) begin
      pipe_vld[i]  = 1'b0;
      pipe_data[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_ir", 32'(ir_data), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_we", 32'(ir_we), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    rst = 1'b0;
    step();

    // Single fetch from PC 0
    mem[0] = 16'h1234;
    do_fetch("single", 16'h0000, 16'h1234, 16'h0001);

    // Three back-to-back fetches with fetch_req held high
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem[0] = 16'hA001;
    mem[1] = 16'hA002;
    mem[2] = 16'hA003;
    exp_seq[0] = 16'hA001;
    exp_seq[1] = 16'hA002;
    exp_seq[2] = 16'hA003;
    fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_we($sformatf("b2b%0d", k), n);
      check($sformatf("b2b%0d_data", k), 32'(ir_data), 32'(exp_seq[k]));
      if (k == 2) fetch_req = 1'b0;
      step();
    end
    check("b2b_pc", 32'(pc), 32'd3);
    step();
    check("b2b_idle", 32'(busy), 32'd0);

    // Jump and fetch in the same request
    mem[16'h00F0] = 16'hBEEF;
    jump_en   = 1'b1;
    jump_addr = 16'h00F0;
    do_fetch("jumpfetch", 16'h00F0, 16'hBEEF, 16'h00F1);

    // Jump-only to the top of memory, then fetch with PC wraparound
    jump_en   = 1'b1;
    jump_addr = 16'hFFFF;
    step();
    jump_en = 1'b0;
    check("jmp_pc", 32'(pc), 32'hFFFF);
    check("jmp_busy", 32'(busy), 32'd0);
    check("jmp_addr_hold", 32'(mem_addr), 32'h00F0);
    mem[16'hFFFF] = 16'hC0DE;
    do_fetch("wrap", 16'hFFFF, 16'hC0DE, 16'h0000);

    // fetch_req and jump_en pulsed during WAIT are ignored
    mem[0] = 16'hA001;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    check("ign_busy", 32'(busy), 32'd1);
    fetch_req = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 16'h1234;
    step();
    fetch_req = 1'b0;
    jump_en   = 1'b0;
    we_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ir_we) we_cnt++;
      if (mem_rd_en) rd_cnt++;
    end
    check("ign_we_count", 32'(we_cnt), 32'd1);
    check("ign_rd_count", 32'(rd_cnt), 32'd0);
    check("ign_pc", 32'(pc), 32'd1);
    check("ign_data", 32'(ir_data), 32'hA001);

    // Reset during WAIT aborts the fetch
    mem[1] = 16'hA002;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_ir", 32'(ir_data), 32'd0);
    check("abort_we", 32'(ir_we), 32'd0);
    rst = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ir_we) we_cnt++;
    end
    check("abort_we_count", 32'(we_cnt), 32'd0);
    check("abort_pc_after", 32'(pc), 32'd0);

`ifdef INSTR_FETCH_HALT_EN
    // Halt opcode stops fetching and freezes the PC
    mem[0] = 16'hF000;
    check("halt_init", 32'(halted), 32'd0);
    do_fetch("halt", 16'h0000, 16'hF000, 16'h0000);
    check("halt_flag", 32'(halted), 32'd1);
    fetch_req = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_rd_en) rd_cnt++;
    end
    fetch_req = 1'b0;
    check("halt_no_rd", 32'(rd_cnt), 32'd0);
    check("halt_pc", 32'(pc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
